// File: rtl/ps2_pkg.sv
// PS/2 command queue shared definitions:
// device response codes, issue states and error causes.
package ps2_pkg;

   localparam int DATA_W = 8;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_TX,
      WAIT_ACK,
      ERROR
   } issue_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_TX_TMO  = 2'b01,
      ERR_ACK_TMO = 2'b10,
      ERR_RETRY   = 2'b11
   } err_code_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through byte FIFO holding queued PS/2 commands.
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_sync_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ps2_tx_queue.sv
// Command queue and issue sequencer feeding the PS/2 host transmitter:
// issues one byte at a time, waits for ACK, retries on RESEND.
module ps2_tx_queue
   import ps2_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int MAX_RETRY   = 3,
   parameter int TX_TIMEOUT  = 2000000,
   parameter int ACK_TIMEOUT = 2000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   tx_w_enable,
   output logic [7:0]             tx_data,
   input  logic                   tx_finished,
   input  logic                   rx_done,
   input  logic [7:0]             rx_data,
   output logic                   busy,
   output logic                   ack_pulse,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic                   overflow,
   input  logic                   clr_err
);

   localparam int TW = $clog2(max_int(TX_TIMEOUT, ACK_TIMEOUT));
   localparam int RW = $clog2(MAX_RETRY + 1);

   localparam logic [TW-1:0] TX_LAST   = TW'(TX_TIMEOUT - 1);
   localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

   issue_state_e  state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          wen_q, wen_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          ovf_q, ovf_d;
   err_code_e     code_q, code_d;

   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic          new_err;
   err_code_e     new_code;
   logic          rx_ack;
   logic          rx_resend;

   ps2_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en),
      .pop   (fifo_pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign rx_ack    = rx_done && (rx_data == PS2_ACK);
   assign rx_resend = rx_done && (rx_data == PS2_RESEND);

   assign full        = fifo_full;
   assign empty       = fifo_empty;
   assign tx_w_enable = wen_q;
   assign tx_data     = tx_data_q;
   assign busy        = (state_q != IDLE);
   assign ack_pulse   = ack_q;
   assign err         = err_q;
   assign err_code    = code_q;
   assign overflow    = ovf_q;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      tx_data_d = tx_data_q;
      wen_d     = 1'b0;
      ack_d     = 1'b0;
      fifo_pop  = 1'b0;
      new_err   = 1'b0;
      new_code  = ERR_NONE;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               tx_data_d = fifo_dout;
               retry_d   = '0;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            wen_d   = 1'b1;
            timer_d = '0;
            state_d = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_finished) begin
               timer_d = '0;
               state_d = WAIT_ACK;
            end else if (timer_q == TX_LAST) begin
               new_err  = 1'b1;
               new_code = ERR_TX_TMO;
               state_d  = ERROR;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_ACK: begin
            // Unrelated bytes fall through so the timeout keeps running.
            if (rx_ack) begin
               ack_d   = 1'b1;
               state_d = IDLE;
            end else if (rx_resend && (retry_q < RETRY_LIM)) begin
               retry_d = retry_q + 1'b1;
               state_d = ISSUE;
            end else if (rx_resend) begin
               new_err  = 1'b1;
               new_code = ERR_RETRY;
               state_d  = ERROR;
            end else if (timer_q == ACK_LAST) begin
               new_err  = 1'b1;
               new_code = ERR_ACK_TMO;
               state_d  = ERROR;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ERROR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // First error wins unless it is being cleared in the same cycle.
   always_comb begin
      err_d  = err_q && !clr_err;
      code_d = clr_err ? ERR_NONE : code_q;
      ovf_d  = (ovf_q && !clr_err) || (wr_en && fifo_full);
      if (new_err && (!err_q || clr_err)) begin
         err_d  = 1'b1;
         code_d = new_code;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         retry_q   <= '0;
         tx_data_q <= '0;
         wen_q     <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         tx_data_q <= tx_data_d;
         wen_q     <= wen_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         code_q    <= code_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ps2_tx_queue.sv
// Bench for ps2_tx_queue: queue/response model checked every cycle
// plus directed command sequences with literal expectations.
module tb_ps2_tx_queue;

   localparam int DEPTH = 4;
   localparam int MAXR  = 2;
   localparam int TXT   = 50;
   localparam int ACKT  = 50;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       tx_w_enable;
   logic [7:0] tx_data;
   logic       tx_finished;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       busy;
   logic       ack_pulse;
   logic       err;
   logic [1:0] err_code;
   logic       overflow;
   logic       clr_err;

   int n_tests = 0;
   int n_fail  = 0;

   ps2_tx_queue #(
      .DEPTH       (DEPTH),
      .MAX_RETRY   (MAXR),
      .TX_TIMEOUT  (TXT),
      .ACK_TIMEOUT (ACKT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .tx_w_enable (tx_w_enable),
      .tx_data     (tx_data),
      .tx_finished (tx_finished),
      .rx_done     (rx_done),
      .rx_data     (rx_data),
      .busy        (busy),
      .ack_pulse   (ack_pulse),
      .err         (err),
      .err_code    (err_code),
      .overflow    (overflow),
      .clr_err     (clr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a byte queue plus the phase of the byte in flight.
   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_TX   = 2;
   localparam int P_ACK  = 3;
   localparam int P_DROP = 4;

   logic [7:0] mq[$];
   int         ph    = P_IDLE;
   int         cyc   = 0;
   int         t0    = 0;
   int         tries = 0;
   bit         mdl_on = 0;
   logic [7:0] e_txd;
   bit         e_wen, e_ack, e_err, e_ovf;
   logic [1:0] e_code;

   always @(posedge clk) begin : model
      int         occ;
      bit         raise;
      bit         was_err;
      logic [1:0] rc;
      cyc++;
      occ   = mq.size();
      raise = 0;
      rc    = 2'b00;
      e_wen = 0;
      e_ack = 0;
      if (reset) begin
         mq.delete();
         ph     = P_IDLE;
         e_txd  = 8'h00;
         e_err  = 0;
         e_code = 2'b00;
         e_ovf  = 0;
         tries  = 0;
         mdl_on = 1;
      end else begin
         case (ph)
            P_IDLE: if (occ > 0) begin
               e_txd = mq.pop_front();
               tries = 0;
               ph    = P_LOAD;
            end
            P_LOAD: begin
               e_wen = 1;
               t0    = cyc;
               ph    = P_TX;
            end
            P_TX: begin
               if (tx_finished) begin
                  t0 = cyc;
                  ph = P_ACK;
               end else if (cyc - t0 == TXT) begin
                  raise = 1;
                  rc    = 2'b01;
               end
            end
            P_ACK: begin
               if (rx_done && rx_data == 8'hFA) begin
                  e_ack = 1;
                  ph    = P_IDLE;
               end else if (rx_done && rx_data == 8'hFE) begin
                  if (tries < MAXR) begin
                     tries++;
                     ph = P_LOAD;
                  end else begin
                     raise = 1;
                     rc    = 2'b11;
                  end
               end else if (cyc - t0 == ACKT) begin
                  raise = 1;
                  rc    = 2'b10;
               end
            end
            default: ph = P_IDLE;
         endcase
         if (raise) ph = P_DROP;
         was_err = e_err;
         if (clr_err) begin
            e_err  = 0;
            e_code = 2'b00;
            e_ovf  = 0;
         end
         if (raise && (!was_err || clr_err)) begin
            e_err  = 1;
            e_code = rc;
         end
         if (wr_en) begin
            if (occ == DEPTH) e_ovf = 1;
            else mq.push_back(wr_data);
         end
      end
   end

   always @(negedge clk) begin
      if (mdl_on) begin
         chk("count", count, mq.size());
         chk("empty", empty, mq.size() == 0);
         chk("full", full, mq.size() == DEPTH);
         chk("busy", busy, ph != P_IDLE);
         chk("tx_w_enable", tx_w_enable, e_wen);
         chk("tx_data", tx_data, e_txd);
         chk("ack_pulse", ack_pulse, e_ack);
         chk("err", err, e_err);
         chk("err_code", err_code, e_code);
         chk("overflow", overflow, e_ovf);
      end
   end

   logic [7:0] slog[$];
   int         nack = 0;

   always @(posedge clk) begin
      #1;
      if (tx_w_enable === 1'b1) slog.push_back(tx_data);
      if (ack_pulse === 1'b1) nack++;
   end

   task automatic wr(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_fin();
      tx_finished = 1'b1;
      @(negedge clk);
      tx_finished = 1'b0;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   task automatic wait_strobe();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_w_enable !== 1'b1 && n < 200);
      chk("strobe_seen", tx_w_enable, 1'b1);
   endtask

   task automatic serve(input logic [7:0] rsp);
      wait_strobe();
      repeat (10) @(negedge clk);
      pulse_fin();
      repeat (3) @(negedge clk);
      pulse_rx(rsp);
   endtask

   initial begin
      int b;
      int na;
      int n;
      reset       = 1'b1;
      wr_en       = 1'b0;
      wr_data     = 8'h00;
      tx_finished = 1'b0;
      rx_done     = 1'b0;
      rx_data     = 8'h00;
      clr_err     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_txdata", tx_data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_wen", tx_w_enable, 0);
      reset = 1'b0;
      @(negedge clk);

      pulse_fin();
      pulse_rx(8'hFA);
      repeat (3) @(negedge clk);
      chk("spurious_ack", nack, 0);
      chk("spurious_busy", busy, 0);

      wr(8'hED);
      wr(8'h02);
      serve(8'hFA);
      serve(8'hFA);
      repeat (4) @(negedge clk);
      chk("t1_strobes", slog.size(), 2);
      chk("t1_b0", slog[0], 8'hED);
      chk("t1_b1", slog[1], 8'h02);
      chk("t1_acks", nack, 2);
      chk("t1_err", err, 0);
      chk("t1_empty", empty, 1);

      b  = slog.size();
      na = nack;
      wr(8'hF3);
      serve(8'hFE);
      serve(8'hFE);
      serve(8'hFA);
      repeat (4) @(negedge clk);
      chk("t2_strobes", slog.size(), b + 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_b%0d", i), slog[b+i], 8'hF3);
      end
      chk("t2_acks", nack, na + 1);
      chk("t2_err", err, 0);

      b  = slog.size();
      na = nack;
      wr(8'hFF);
      wr(8'hAB);
      serve(8'hFE);
      serve(8'hFE);
      serve(8'hFE);
      serve(8'hFA);
      repeat (4) @(negedge clk);
      chk("t3_strobes", slog.size(), b + 4);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t3_b%0d", i), slog[b+i], 8'hFF);
      end
      chk("t3_next", slog[b+3], 8'hAB);
      chk("t3_acks", nack, na + 1);
      chk("t3_err", err, 1);
      chk("t3_code", err_code, 2'b11);
      pulse_clr();
      chk("t3_clr_err", err, 0);
      chk("t3_clr_code", err_code, 2'b00);

      wr(8'hEE);
      wait_strobe();
      n = 0;
      while (err !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t4_latency", n, 50);
      chk("t4_code", err_code, 2'b01);
      pulse_clr();
      chk("t4_clr_err", err, 0);

      b  = slog.size();
      na = nack;
      wr(8'h10);
      wait_strobe();
      wr(8'h11);
      wr(8'h22);
      wr(8'h33);
      wr(8'h44);
      wr(8'h55);
      chk("t5_count", count, 4);
      chk("t5_full", full, 1);
      chk("t5_ovf", overflow, 1);
      pulse_fin();
      repeat (3) @(negedge clk);
      pulse_rx(8'hFA);
      for (int i = 0; i < 4; i++) serve(8'hFA);
      repeat (30) @(negedge clk);
      chk("t5_strobes", slog.size(), b + 5);
      chk("t5_b0", slog[b], 8'h10);
      chk("t5_b1", slog[b+1], 8'h11);
      chk("t5_b4", slog[b+4], 8'h44);
      chk("t5_acks", nack, na + 5);
      chk("t5_empty", empty, 1);
      chk("t5_ovf_sticky", overflow, 1);

      wr(8'h61);
      wait_strobe();
      wr(8'h62);
      wr(8'h63);
      wr(8'h64);
      pulse_fin();
      repeat (3) @(negedge clk);
      chk("t6_pre_count", count, 3);
      chk("t6_pre_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t6_empty", empty, 1);
      chk("t6_busy", busy, 0);
      chk("t6_wen", tx_w_enable, 0);
      chk("t6_ovf", overflow, 0);
      b  = slog.size();
      na = nack;
      pulse_rx(8'hFA);
      repeat (20) @(negedge clk);
      chk("t6_no_ack", nack, na);
      chk("t6_no_strobe", slog.size(), b);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
